// File: rtl/frq_pkg.sv
// Shared constants for the frequency divider / meter pair: code width,
// nominal half-period table and the meter FSM states.
package frq_pkg;

    localparam int NUM_CODES = 32;
    localparam int CODE_W    = 5;
    localparam int HALF_W    = 8;
    localparam int PERIOD_W  = HALF_W + 1;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_MEASURE = 2'd1,
        ST_SEARCH  = 2'd2,
        ST_DONE    = 2'd3
    } frq_state_e;

    // Divider half-period for a select code: 4*(code+1) clk cycles.
    function automatic logic [HALF_W-1:0] half_period(input logic [CODE_W-1:0] code);
        logic [HALF_W-1:0] k_s;
        k_s = {{(HALF_W-CODE_W){1'b0}}, code} + 8'd1;
        return {k_s[HALF_W-3:0], 2'b00};
    endfunction

    // Full nominal period produced by the divider for a select code.
    function automatic logic [PERIOD_W-1:0] nominal_period(input logic [CODE_W-1:0] code);
        return {half_period(code), 1'b0};
    endfunction

endpackage

// File: rtl/frq_meter_edge_sync.sv
// Two-flop synchronizer for the asynchronous input plus a third flop that
// turns its rising transition into a one-cycle pulse.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain and edge-detect history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/frq_meter.sv
// Measures the period of an external square wave and maps it back to the
// divider select code whose nominal period lies within TOL cycles.
module frq_meter
    import frq_pkg::*;
#(
    parameter int CNT_W   = 12,
    parameter int TOL     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sig_in,
    output logic [CODE_W-1:0] f_code,
    output logic              f_valid,
    output logic              no_match,
    output logic              no_signal,
    output logic              meas_done,
    output logic [CNT_W-1:0]  period_out
);

    localparam int                EXT_W     = CNT_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [EXT_W-1:0]  TOL_C     = EXT_W'(TOL);
    localparam logic [CODE_W-1:0] LAST_IDX  = CODE_W'(NUM_CODES - 1);

    frq_state_e        state_r;
    frq_state_e        state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CODE_W-1:0] idx_r;
    logic [CODE_W-1:0] idx_s;
    logic              rise_s;
    logic              tmo_s;
    logic [EXT_W-1:0]  meas_ext_s;
    logic [EXT_W-1:0]  nom_ext_s;
    logic [EXT_W-1:0]  diff_s;
    logic              hit_s;
    logic [CODE_W-1:0] f_code_s;
    logic              f_valid_s;
    logic              no_match_s;
    logic              no_signal_s;
    logic              meas_done_s;
    logic [CNT_W-1:0]  period_s;

    edge_sync u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (rise_s)
    );

    // Period counter: restarts at 1 on every edge, saturates at full scale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            cnt_r <= CNT_W'(1);
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tmo_s = (cnt_r >= TIMEOUT_C);

    // Table compare for the current search index; a saturated capture never matches.
    always_comb begin
        meas_ext_s = {1'b0, period_out};
        nom_ext_s  = EXT_W'(nominal_period(idx_r));
        if (meas_ext_s >= nom_ext_s) begin
            diff_s = meas_ext_s - nom_ext_s;
        end else begin
            diff_s = nom_ext_s - meas_ext_s;
        end
        hit_s = (diff_s <= TOL_C) && (period_out != CNT_MAX);
    end

    // Next-state and next-output logic; results are posted on entry to DONE.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        f_code_s    = f_code;
        f_valid_s   = f_valid;
        no_match_s  = no_match;
        meas_done_s = 1'b0;
        period_s    = period_out;
        if (rise_s) begin
            no_signal_s = 1'b0;
        end else begin
            no_signal_s = no_signal;
        end
        case (state_r)
            ST_ARM: begin
                if (rise_s) begin
                    state_s = ST_MEASURE;
                end else if (tmo_s) begin
                    no_signal_s = 1'b1;
                    f_valid_s   = 1'b0;
                    no_match_s  = 1'b0;
                    state_s     = ST_ARM;
                end else begin
                    state_s = ST_ARM;
                end
            end
            ST_MEASURE: begin
                if (rise_s) begin
                    period_s = cnt_r;
                    idx_s    = {CODE_W{1'b0}};
                    state_s  = ST_SEARCH;
                end else if (tmo_s) begin
                    no_signal_s = 1'b1;
                    f_valid_s   = 1'b0;
                    no_match_s  = 1'b0;
                    state_s     = ST_ARM;
                end else begin
                    state_s = ST_MEASURE;
                end
            end
            ST_SEARCH: begin
                if (hit_s) begin
                    f_code_s    = idx_r;
                    f_valid_s   = 1'b1;
                    no_match_s  = 1'b0;
                    meas_done_s = 1'b1;
                    state_s     = ST_DONE;
                end else if (idx_r == LAST_IDX) begin
                    f_valid_s   = 1'b0;
                    no_match_s  = 1'b1;
                    meas_done_s = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    idx_s = idx_r + CODE_W'(1);
                end
            end
            ST_DONE: begin
                idx_s   = {CODE_W{1'b0}};
                state_s = ST_ARM;
            end
            default: begin
                idx_s   = {CODE_W{1'b0}};
                state_s = ST_ARM;
            end
        endcase
    end

    // State, search index and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_ARM;
            idx_r      <= {CODE_W{1'b0}};
            f_code     <= {CODE_W{1'b0}};
            f_valid    <= 1'b0;
            no_match   <= 1'b0;
            no_signal  <= 1'b0;
            meas_done  <= 1'b0;
            period_out <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            f_code     <= f_code_s;
            f_valid    <= f_valid_s;
            no_match   <= no_match_s;
            no_signal  <= no_signal_s;
            meas_done  <= meas_done_s;
            period_out <= period_s;
        end
    end

endmodule
